// File: rtl/drive_pkg.sv
// drive_pkg: shared definitions for the PWM drive controller and the PWM
// capture block. Holds the default link parameters so both ends agree on
// frame length, prescale, and timeout, and defines the capture FSM state type.
package drive_pkg;

    // One PWM frame is 2^PWM_RESOLUTION ticks.
    localparam int unsigned PWM_RESOLUTION_DEF = 8;
    // Clocks per PWM tick. This must match the prescaler on the drive side.
    localparam int unsigned PRESCALE_DEF       = 10;
    // Number of whole frames the line may stay low before it is declared dead.
    localparam int unsigned TIMEOUT_FRAMES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } cap_state_e;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: two-flop synchronizer for one asynchronous line. It also
// produces single-clock rise and fall pulses, which are derived from the
// synchronized value.
//   clk_i   : clock
//   reset_i : asynchronous active-high reset; clears all flops
//   async_i : asynchronous input line
//   sync_o  : synchronized level (two flops after the pin)
//   rise_o  : one-clock pulse when sync_o goes 0 -> 1
//   fall_o  : one-clock pulse when sync_o goes 1 -> 0
module sync_edge (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: decodes the duty-cycle PWM stream from the drive controller
// into a borehole code and a direction bit. It also flags frames of the
// wrong length and a line that is stuck low.
//   clk_i         : clock; all logic runs on its rising edge
//   reset_i       : asynchronous active-high reset
//   enable_i      : capture enable; when low, the block idles and holds its outputs
//   PWM_i         : asynchronous PWM line
//   direction_i   : asynchronous direction line
//   borehole_o    : decoded duty code (high_ticks - 1, clamped)
//   direction_o   : direction latched during the published frame
//   valid_o       : one-clock pulse for each new measurement
//   period_err_o  : the last published frame was not 2^PWM_RESOLUTION ticks long
//   timeout_o     : PWM line stuck low
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no phase reference; wait for a rising edge, publish nothing
// HIGH  | timing the high phase; publish all-ones if it lasts a whole frame
// LOW   | timing the low phase; the next rise publishes, a long low times out
module pwm_capture
    import drive_pkg::*;
#(
    parameter int unsigned PWM_RESOLUTION = PWM_RESOLUTION_DEF,
    parameter int unsigned PRESCALE       = PRESCALE_DEF,
    parameter int unsigned TIMEOUT_FRAMES = TIMEOUT_FRAMES_DEF
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      enable_i,
    input  logic                      PWM_i,
    input  logic                      direction_i,
    output logic [PWM_RESOLUTION-1:0] borehole_o,
    output logic                      direction_o,
    output logic                      valid_o,
    output logic                      period_err_o,
    output logic                      timeout_o
);

    localparam int unsigned FRAME_TICKS = 2 ** PWM_RESOLUTION;
    localparam int unsigned TO_TICKS    = TIMEOUT_FRAMES * FRAME_TICKS;
    localparam int unsigned CW          = $clog2(TO_TICKS + 1);
    localparam int unsigned SW          = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [CW-1:0] FRAME_C   = CW'(FRAME_TICKS);
    localparam logic [CW-1:0] TO_C      = CW'(TO_TICKS);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] CODE_MAX  = CW'(FRAME_TICKS - 1);
    localparam logic [SW-1:0] SUB_LAST  = SW'(PRESCALE - 1);
    localparam logic [SW-1:0] SUB_HALF  = SW'(PRESCALE / 2);
    localparam logic [SW-1:0] SUB_FIRST = SW'(1);

    logic pwm_sync, pwm_rise, pwm_fall;
    logic dir_sync, dir_rise_unused, dir_fall_unused;

    cap_state_e state_q, state_d;

    logic [SW-1:0]             sub_q, sub_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [CW-1:0]             high_q, high_d;
    logic                      dir_lat_q, dir_lat_d;
    logic [PWM_RESOLUTION-1:0] borehole_q, borehole_d;
    logic                      direction_q, direction_d;
    logic                      valid_q, valid_d;
    logic                      perr_q, perr_d;
    logic                      timeout_q, timeout_d;

    logic                      any_edge, sub_wrap, high_full, low_expired, frame_bad;
    logic [CW-1:0]             cnt_step, closing_ticks, high_m1;
    logic [CW:0]               frame_sum;
    logic [PWM_RESOLUTION-1:0] code_clamped;

    sync_edge u_sync_pwm (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .async_i (PWM_i),
        .sync_o  (pwm_sync),
        .rise_o  (pwm_rise),
        .fall_o  (pwm_fall)
    );

    // Direction needs only the synchronized level.
    sync_edge u_sync_dir (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .async_i (direction_i),
        .sync_o  (dir_sync),
        .rise_o  (dir_rise_unused),
        .fall_o  (dir_fall_unused)
    );

    assign any_edge = pwm_rise | pwm_fall;
    assign sub_wrap = (sub_q == SUB_LAST);
    assign cnt_step = (sub_wrap && (cnt_q != CNT_MAX)) ? cnt_q + CW'(1) : cnt_q;

    // Round the phase that is closing: whole ticks, plus one if at least
    // half a tick is left over.
    assign closing_ticks = ((sub_q >= SUB_HALF) && (cnt_q != CNT_MAX)) ? cnt_q + CW'(1) : cnt_q;

    assign high_full   = (state_q == HIGH) && !any_edge && (cnt_step == FRAME_C);
    assign low_expired = (state_q == LOW)  && !any_edge && (cnt_step == TO_C);

    assign high_m1   = high_q - CW'(1);
    assign frame_sum = {1'b0, high_q} + {1'b0, closing_ticks};
    assign frame_bad = (frame_sum != {1'b0, FRAME_C});

    always_comb begin
        code_clamped = '0;
        if (high_q == '0) begin
            code_clamped = '0;
        end else if (high_m1 > CODE_MAX) begin
            code_clamped = '1;
        end else begin
            code_clamped = high_m1[PWM_RESOLUTION-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (pwm_rise) state_d = HIGH;
                HIGH: if (pwm_fall) state_d = LOW;
                LOW: begin
                    if (pwm_rise) begin
                        state_d = HIGH;
                    end else if (low_expired) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sub_d       = sub_q;
        cnt_d       = cnt_q;
        high_d      = high_q;
        dir_lat_d   = dir_lat_q;
        borehole_d  = borehole_q;
        direction_d = direction_q;
        perr_d      = perr_q;
        timeout_d   = timeout_q;
        valid_d     = 1'b0;

        if (!enable_i) begin
            sub_d  = '0;
            cnt_d  = '0;
            high_d = '0;
        end else if (any_edge) begin
            // The clock on which an edge is seen is the first clock of the new phase.
            sub_d = SUB_FIRST;
            cnt_d = '0;
            if (pwm_rise) begin
                timeout_d = 1'b0;
            end
            if ((state_q == HIGH) && pwm_fall) begin
                high_d    = closing_ticks;
                dir_lat_d = dir_sync;
            end
            if ((state_q == LOW) && pwm_rise) begin
                borehole_d  = code_clamped;
                direction_d = dir_lat_q;
                perr_d      = frame_bad;
                valid_d     = 1'b1;
            end
        end else if (state_q == IDLE) begin
            sub_d = '0;
            cnt_d = '0;
        end else begin
            sub_d = sub_wrap ? '0 : sub_q + SW'(1);
            cnt_d = cnt_step;
            if (high_full) begin
                // Line held high for a whole frame: report full scale and keep timing.
                borehole_d  = '1;
                direction_d = dir_sync;
                perr_d      = 1'b0;
                valid_d     = 1'b1;
                cnt_d       = '0;
            end
            if (low_expired) begin
                timeout_d  = 1'b1;
                borehole_d = '0;
                cnt_d      = '0;
                sub_d      = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sub_q       <= '0;
            cnt_q       <= '0;
            high_q      <= '0;
            dir_lat_q   <= 1'b0;
            borehole_q  <= '0;
            direction_q <= 1'b0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            sub_q       <= sub_d;
            cnt_q       <= cnt_d;
            high_q      <= high_d;
            dir_lat_q   <= dir_lat_d;
            borehole_q  <= borehole_d;
            direction_q <= direction_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            timeout_q   <= timeout_d;
        end
    end

    assign borehole_o   = borehole_q;
    assign direction_o  = direction_q;
    assign valid_o      = valid_q;
    assign period_err_o = perr_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives directed PWM frames into pwm_capture. Expected
// measurements are queued when a frame's closing edge is driven. A negedge
// monitor checks every valid_o pulse against that queue and also checks
// queued output probes.
module tb_pwm_capture;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       enable_i;
    logic       PWM_i;
    logic       direction_i;
    logic [7:0] borehole_o;
    logic       direction_o;
    logic       valid_o;
    logic       period_err_o;
    logic       timeout_o;

    pwm_capture dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .enable_i     (enable_i),
        .PWM_i        (PWM_i),
        .direction_i  (direction_i),
        .borehole_o   (borehole_o),
        .direction_o  (direction_o),
        .valid_o      (valid_o),
        .period_err_o (period_err_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] code;
        logic       dir;
        logic       perr;
        logic       lat;
    } exp_t;

    typedef struct {
        string      name;
        logic       drain;
        logic [7:0] code;
        logic       dir;
        logic       perr;
        logic       tmo;
    } probe_t;

    exp_t   sb_q[$];
    probe_t pq[$];
    exp_t   ex;
    probe_t pr;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rise_cyc = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (pq.size() > 0) begin
            pr = pq.pop_front();
            if (pr.drain) begin
                cmp({pr.name, "_pending"}, sb_q.size(), 0);
            end else begin
                cmp({pr.name, "_borehole"}, borehole_o, pr.code);
                cmp({pr.name, "_direction"}, direction_o, pr.dir);
                cmp({pr.name, "_period_err"}, period_err_o, pr.perr);
                cmp({pr.name, "_timeout"}, timeout_o, pr.tmo);
                cmp({pr.name, "_valid"}, valid_o, 0);
            end
        end
        if (valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got valid with borehole %0d, expected no valid", borehole_o);
            end else begin
                ex = sb_q.pop_front();
                cmp("pub_borehole", borehole_o, ex.code);
                cmp("pub_direction", direction_o, ex.dir);
                cmp("pub_period_err", period_err_o, ex.perr);
                if (ex.lat) cmp("pub_latency", cyc - rise_cyc, 3);
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic expect_pub(input logic [7:0] c, input logic d, input logic pe, input logic lat);
        exp_t e;
        e.code = c; e.dir = d; e.perr = pe; e.lat = lat;
        sb_q.push_back(e);
    endtask

    task automatic probe(input string nm, input logic [7:0] c, input logic d, input logic pe, input logic t);
        probe_t p;
        p.name = nm; p.drain = 1'b0; p.code = c; p.dir = d; p.perr = pe; p.tmo = t;
        pq.push_back(p);
    endtask

    task automatic drain_probe();
        probe_t p;
        p.name = "final"; p.drain = 1'b1; p.code = '0; p.dir = 1'b0; p.perr = 1'b0; p.tmo = 1'b0;
        pq.push_back(p);
    endtask

    // Drives one frame. The rising edge that opens this frame publishes the
    // previous one, so the expected values describe the previous frame.
    task automatic frame(input int h, input int l, input logic d,
                         input logic pub, input logic [7:0] c, input logic pd, input logic pe);
        if (pub) expect_pub(c, pd, pe, 1'b1);
        rise_cyc = cyc;
        PWM_i = 1'b1;
        direction_i = d;
        clks(h);
        PWM_i = 1'b0;
        clks(l);
    endtask

    initial begin
        reset_i = 1'b1;
        enable_i = 1'b1;
        PWM_i = 1'b0;
        direction_i = 1'b0;
        clks(2);
        probe("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        clks(2);
        reset_i = 1'b0;
        clks(5);

        // Steady borehole 0x80 with direction 1: the first frame only arms the capture.
        frame(1290, 1270, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        frame(1290, 1270, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0);
        frame(1290, 1270, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0);
        frame(1290, 1270, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0);

        // Borehole 0x00: a 10-clock high pulse in each 2560-clock frame.
        frame(10, 2550, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0);
        frame(10, 2550, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        frame(10, 2550, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

        // Line held high: the rise publishes 0x00, then 0xFF every 2560 clocks.
        expect_pub(8'h00, 1'b0, 1'b0, 1'b1);
        expect_pub(8'hFF, 1'b0, 1'b0, 1'b0);
        expect_pub(8'hFF, 1'b0, 1'b0, 1'b0);
        expect_pub(8'hFF, 1'b0, 1'b0, 1'b0);
        rise_cyc = cyc;
        PWM_i = 1'b1;
        clks(8000);

        // Stuck low: time out without a publish, then recover on the next rise.
        PWM_i = 1'b0;
        clks(5300);
        probe("timeout_set", 8'h00, 1'b0, 1'b0, 1'b1);
        PWM_i = 1'b1;
        direction_i = 1'b1;
        clks(5);
        probe("timeout_clr", 8'h00, 1'b0, 1'b0, 1'b0);
        clks(495);
        PWM_i = 1'b0;
        clks(1500);

        // 2000-clock frames with 500 clocks high, some with jittered phase lengths.
        frame(500, 1500, 1'b0, 1'b1, 8'h31, 1'b1, 1'b1);
        frame(504, 1496, 1'b1, 1'b1, 8'h31, 1'b0, 1'b1);
        frame(496, 1504, 1'b0, 1'b1, 8'h31, 1'b1, 1'b1);
        frame(500, 1500, 1'b1, 1'b1, 8'h31, 1'b0, 1'b1);

        // Reset asserted in the middle of a high phase.
        expect_pub(8'h31, 1'b1, 1'b1, 1'b1);
        rise_cyc = cyc;
        PWM_i = 1'b1;
        direction_i = 1'b0;
        clks(200);
        #2;
        reset_i = 1'b1;
        PWM_i = 1'b0;
        probe("reset_async", 8'h00, 1'b0, 1'b0, 1'b0);
        clks(3);
        reset_i = 1'b0;
        clks(20);
        probe("post_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        frame(1290, 1270, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        frame(1290, 1270, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0);

        // Enable dropped for 100 clocks in the middle of a high phase.
        expect_pub(8'h80, 1'b1, 1'b0, 1'b1);
        rise_cyc = cyc;
        PWM_i = 1'b1;
        direction_i = 1'b0;
        clks(500);
        enable_i = 1'b0;
        probe("disable_start", 8'h80, 1'b1, 1'b0, 1'b0);
        clks(100);
        probe("disable_end", 8'h80, 1'b1, 1'b0, 1'b0);
        enable_i = 1'b1;
        clks(690);
        PWM_i = 1'b0;
        clks(1270);
        frame(650, 1910, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        frame(170, 2390, 1'b1, 1'b1, 8'h40, 1'b0, 1'b0);
        frame(1290, 1270, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0);

        drain_probe();
        clks(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter PWM_RESOLUTION, default 8: duty-code width; one PWM frame is 2^PWM_RESOLUTION ticks.
REQ-002 SHALL have parameter PRESCALE, default 10: clocks per PWM tick, equal to the drive-side prescaler.
REQ-003 SHALL have parameter TIMEOUT_FRAMES, default 2: low-line frames before timeout.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port enable_i, input, 1 bit: capture enable.
REQ-007 SHALL have port PWM_i, input, 1 bit: asynchronous PWM line from the drive controller.
REQ-008 SHALL have port direction_i, input, 1 bit: asynchronous direction line.
REQ-009 SHALL have port borehole_o, output, PWM_RESOLUTION bits: decoded duty code.
REQ-010 SHALL have port direction_o, output, 1 bit: decoded direction.
REQ-011 SHALL have port valid_o, output, 1 bit: one-clock pulse on each new measurement.
REQ-012 SHALL have port period_err_o, output, 1 bit: last published frame length was not 2^PWM_RESOLUTION ticks.
REQ-013 SHALL have port timeout_o, output, 1 bit: PWM line stuck low.

Function
REQ-014 SHALL pass PWM_i and direction_i each through a 2-flop synchronizer; PWM edge detect SHALL run on the synchronized value.
REQ-015 SHALL count clocks with a sub-counter, 0..PRESCALE-1, that restarts on every synchronized PWM edge; each wrap adds one tick to the active phase count.
REQ-016 SHALL round each phase on its closing edge: ticks = completed blocks + (remainder >= PRESCALE/2), giving tolerance of ±(PRESCALE/2 - 1) clocks of edge jitter.
REQ-017 SHALL use FSM states IDLE, HIGH, LOW.
REQ-018 IDLE SHALL go to HIGH on a synchronized rising edge; nothing is published on this first edge.
REQ-019 HIGH SHALL, on a falling edge, latch high_ticks and the synchronized direction, then go to LOW.
REQ-020 LOW SHALL, on a rising edge, publish a measurement and go to HIGH.
REQ-021 A published measurement SHALL set borehole_o = high_ticks - 1, clamped to 0..2^PWM_RESOLUTION-1 (high_ticks 0 gives 0).
REQ-022 A published measurement SHALL set direction_o to the latched direction and set period_err_o = (high_ticks + low_ticks != 2^PWM_RESOLUTION).
REQ-023 A published measurement SHALL pulse valid_o exactly one clock, 3 clocks after the PWM_i rising edge at the pin.
REQ-024 When the HIGH tick count reaches 2^PWM_RESOLUTION (line constantly high), the block SHALL publish borehole_o = all-ones, period_err_o = 0, pulse valid_o, clear the counts and stay in HIGH; this repeats every 2^PWM_RESOLUTION ticks.
REQ-025 When the LOW tick count reaches TIMEOUT_FRAMES*2^PWM_RESOLUTION, the block SHALL set timeout_o = 1 and borehole_o = 0, with no valid_o pulse, and go to IDLE.
REQ-026 timeout_o SHALL clear on the next synchronized rising edge.
REQ-027 Tick counters SHALL saturate and never wrap.
REQ-028 A rising and a falling edge cannot both be seen in one clock after synchronization; a glitch shorter than 1 clock SHALL be ignored.
REQ-029 enable_i = 0 SHALL force IDLE and clear the counters, hold borehole_o, direction_o, period_err_o and timeout_o, and hold valid_o at 0; re-enable SHALL wait for a fresh rising edge.

Reset
REQ-030 reset_i = 1 SHALL asynchronously clear borehole_o, direction_o, valid_o, period_err_o, timeout_o, both synchronizers, all counters, and the FSM (to IDLE).
REQ-031 Reset in any state SHALL discard the partial frame; the first frame after release SHALL not publish.

Structure
REQ-032 Shared package drive_pkg SHALL hold PWM_RESOLUTION, PRESCALE, TIMEOUT_FRAMES defaults and the capture state enum, reused by the drive controller.
REQ-033 One sub-module, sync_edge, SHALL provide the 2-flop synchronizer plus rise/fall pulses; it is instantiated for PWM_i, and its synchronized output is used for direction_i.

Verification
REQ-034 Drive-controller model, borehole 0x80, direction 1, steady -> valid_o from the 2nd frame on, borehole_o=0x80, direction_o=1, period_err_o=0.
REQ-035 Borehole 0x00 (10-clock high per 2560-clock frame) -> borehole_o=0x00; then 0xFF (line constant high) -> valid_o every 2560 clocks with 0xFF.
REQ-036 PWM_i low for 5120 clocks after a falling edge -> timeout_o=1, borehole_o=0, no valid_o; next rising edge -> timeout_o=0, no publish.
REQ-037 Frame 2000 clocks with high 500 clocks -> borehole_o=0x31, period_err_o=1; edges jittered ±4 clocks -> same values.
REQ-038 reset_i pulsed mid-HIGH -> all outputs 0 in the same cycle, FSM IDLE; the first post-reset edge produces no valid_o.
REQ-039 enable_i dropped mid-frame for 100 clocks -> outputs held, valid_o low; the first full frame after re-enable publishes correctly.
